// File: rtl/stepper_pkg.sv
// Shared types and timing defaults for the step/dir pulse generator.
// Holds the FSM state enum and the minimum-period helper.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIR_SETUP,
    STEP_HIGH,
    STEP_LOW
  } state_e;

  localparam int unsigned STEP_HIGH_CYC_DEF    = 4;
  localparam int unsigned STEP_LOW_MIN_CYC_DEF = 4;
  localparam int unsigned DIR_SETUP_CYC_DEF    = 8;
  localparam int unsigned DIR_HOLD_CYC_DEF     = 4;

  function automatic int unsigned min_period(
    input int unsigned high_cyc,
    input int unsigned low_min_cyc
  );
    return high_cyc + low_min_cyc;
  endfunction

endpackage

// File: rtl/step_pulse_generator_if.sv
// Move-command valid/ready channel into a step pulse generator.
// master: command source; slave: the generator (drives cmd_ready).
interface step_pulse_generator_if #(
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned PERIOD_W = 16
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/step_interval_timer.sv
// Loadable down-counter timing one interval of load_val cycles.
// Ports: clk, reset_n, load/load_val, en, expired (last cycle).
module step_interval_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic                expired
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N at the entry edge, so the count reads 1
  // in the N-th cycle of the interval.
  assign expired = en && (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/step_pulse_generator.sv
// Step/dir pulse train for one stepper axis from move commands.
// Ports: clk, reset_n, cmd (valid/ready), abort, pos_load/pos_value,
// step, dir, busy, done, aborted, steps_left, position.
module step_pulse_generator
  import stepper_pkg::*;
#(
  parameter int unsigned COUNT_W          = 16,
  parameter int unsigned PERIOD_W         = 16,
  parameter int unsigned POS_W            = 32,
  parameter int unsigned STEP_HIGH_CYC    = STEP_HIGH_CYC_DEF,
  parameter int unsigned STEP_LOW_MIN_CYC = STEP_LOW_MIN_CYC_DEF,
  parameter int unsigned DIR_SETUP_CYC    = DIR_SETUP_CYC_DEF,
  parameter int unsigned DIR_HOLD_CYC     = DIR_HOLD_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  step_pulse_generator_if.slave cmd,
  input  logic                 abort,
  input  logic                 pos_load,
  input  logic [POS_W-1:0]     pos_value,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [COUNT_W-1:0]   steps_left,
  output logic [POS_W-1:0]     position
);

  localparam int unsigned MIN_P_I =
    min_period(STEP_HIGH_CYC, STEP_LOW_MIN_CYC);

  // Low time after an aborted pulse; it must also cover dir hold.
  localparam int unsigned ABORT_LOW_I =
    (DIR_HOLD_CYC > MIN_P_I) ?
    DIR_HOLD_CYC - STEP_HIGH_CYC : STEP_LOW_MIN_CYC;

  localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_P_I);
  localparam logic [PERIOD_W-1:0] HIGH_T    = PERIOD_W'(STEP_HIGH_CYC);
  localparam logic [PERIOD_W-1:0] SETUP_T   = PERIOD_W'(DIR_SETUP_CYC);
  localparam logic [PERIOD_W-1:0] ABORT_LOW = PERIOD_W'(ABORT_LOW_I);

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                ready_q, ready_d;
  logic                abort_pend_q, abort_pend_d;
  logic [COUNT_W-1:0]  steps_left_q, steps_left_d;
  logic [POS_W-1:0]    position_q, position_d;
  logic [PERIOD_W-1:0] period_q, period_d;

  logic                accept;
  logic [PERIOD_W-1:0] eff_period;
  logic [POS_W-1:0]    pos_base;
  logic [POS_W-1:0]    pos_inc;
  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_val;
  logic                tmr_en;
  logic                tmr_exp;

  assign accept = cmd.cmd_valid && ready_q;

  assign eff_period =
    (cmd.cmd_period < MIN_P) ? MIN_P : cmd.cmd_period;

  // +1 when dir=1, all-ones (-1) when dir=0.
  assign pos_inc = {{(POS_W-1){~dir_q}}, 1'b1};

  assign tmr_en = (state_q != IDLE);

  step_interval_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    steps_left_d = steps_left_q;
    position_d   = position_q;
    period_d     = period_q;
    pos_base     = position_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        // A coincident load lands first; the first
        // step then counts from the loaded value.
        if (pos_load) begin
          position_d = pos_value;
          pos_base   = pos_value;
        end
        if (accept) begin
          period_d     = eff_period;
          steps_left_d = cmd.cmd_steps;
          aborted_d    = 1'b0;
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (cmd.cmd_dir != dir_q) begin
            dir_d    = cmd.cmd_dir;
            state_d  = DIR_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_T;
          end else begin
            state_d      = STEP_HIGH;
            step_d       = 1'b1;
            steps_left_d = cmd.cmd_steps - COUNT_W'(1);
            position_d   = pos_base + pos_inc;
            tmr_load     = 1'b1;
            tmr_val      = HIGH_T;
          end
        end
      end

      DIR_SETUP: begin
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (tmr_exp) begin
          state_d      = STEP_HIGH;
          step_d       = 1'b1;
          steps_left_d = steps_left_q - COUNT_W'(1);
          position_d   = position_q + pos_inc;
          tmr_load     = 1'b1;
          tmr_val      = HIGH_T;
        end
      end

      STEP_HIGH: begin
        // Never cut the pulse short; remember the abort.
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (tmr_exp) begin
          state_d  = STEP_LOW;
          step_d   = 1'b0;
          tmr_load = 1'b1;
          if (abort || abort_pend_q) begin
            tmr_val = ABORT_LOW;
          end else begin
            tmr_val = period_q - HIGH_T;
          end
        end
      end

      STEP_LOW: begin
        if (abort || (tmr_exp && abort_pend_q)) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
        end else if (tmr_exp) begin
          if (steps_left_q != '0) begin
            state_d      = STEP_HIGH;
            step_d       = 1'b1;
            steps_left_d = steps_left_q - COUNT_W'(1);
            position_d   = position_q + pos_inc;
            tmr_load     = 1'b1;
            tmr_val      = HIGH_T;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ready_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      steps_left_q <= '0;
      position_q   <= '0;
      period_q     <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      ready_q      <= ready_d;
      abort_pend_q <= abort_pend_d;
      steps_left_q <= steps_left_d;
      position_q   <= position_d;
      period_q     <= period_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign step          = step_q;
  assign dir           = dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign steps_left    = steps_left_q;
  assign position      = position_q;

endmodule
